// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage -- instruction decode stage of a five-stage RV32I pipeline.
//
// Holds the IF/ID pipeline register, the 32x32 integer register file with a
// writeback-to-decode bypass, the immediate generator, and the hazard logic
// that stalls fetch/decode on a load-use dependency and flushes on a branch.
//
// Parameters
//   NOP_INSTR    instruction word placed in IF/ID on reset or flush
//                (default addi x0,x0,0)
//
// Ports
//   CLK          clock; all state changes on the rising edge
//   RST          synchronous, active-high reset
//   InstrF       instruction word from fetch
//   PCPlus4F     PC+4 of the fetched instruction
//   PCSrcM       branch/jump taken, resolved in the M stage
//   ResultSrcE0  the instruction in E is a load
//   RdE          destination register of the instruction in E
//   RegWriteW    writeback enable
//   RdW          writeback destination register
//   ResultW      writeback data
//   StallF       hold the fetch PC
//   FlushE       turn the ID/EX register into a bubble
//   InstrD       instruction held in IF/ID
//   PCPlus4D     PC+4 held in IF/ID
//   PCD          PC of the decode instruction (PCPlus4D - 4)
//   RD1D, RD2D   register file read data for Rs1D / Rs2D (bypassed)
//   ImmExtD      sign-extended immediate selected by opcode
//   Rs1D, Rs2D   source register fields of InstrD
//   RdD          destination register field of InstrD
//   ValidD       InstrD is a real fetched instruction (not reset/flush NOP)
// ============================================================================
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCPlus4F,
    input  logic        PCSrcM,
    input  logic        ResultSrcE0,
    input  logic [4:0]  RdE,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic        StallF,
    output logic        FlushE,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] PCD,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ImmExtD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic        ValidD
);

    // ------------------------------------------------------------------
    // Opcodes that carry an immediate
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] instr_q,   instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q,   valid_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // ------------------------------------------------------------------
    // Combinational decode helpers
    // ------------------------------------------------------------------
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        lw_stall;
    logic        stall_d;
    logic        flush_d;
    logic        wb_en;
    logic [31:0] imm_ext;

    // Register fields are extracted unconditionally; consumers that do not
    // use a field simply ignore it.
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];

    // ------------------------------------------------------------------
    // Hazard unit
    // ------------------------------------------------------------------
    // A load in E whose destination is read by the instruction in D cannot
    // be forwarded in time, so D and F hold for one cycle while E bubbles.
    // The bubble removes the load-match condition on the next cycle, which
    // is what limits the stall to a single cycle.
    assign lw_stall = ResultSrcE0 & (RdE != 5'd0) & ((RdE == rs1) | (RdE == rs2));

    // A taken branch overrides the stall: the stalled instruction is on the
    // wrong path anyway, so fetch must be free to load the target. Reset
    // also releases the stall so the pipeline restarts cleanly.
    assign stall_d = lw_stall & ~PCSrcM & ~RST;
    assign flush_d = PCSrcM;

    assign StallF = stall_d;
    assign FlushE = lw_stall | PCSrcM;

    // ------------------------------------------------------------------
    // IF/ID register next-state
    // ------------------------------------------------------------------
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush_d) begin
            instr_d   = NOP_INSTR;
            pcplus4_d = 32'd0;
            valid_d   = 1'b0;
        end else if (!stall_d) begin
            instr_d   = InstrF;
            pcplus4_d = PCPlus4F;
            valid_d   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register file next-state
    // ------------------------------------------------------------------
    // x0 is hard-wired to zero, so writes to it are dropped here and reads
    // of it are forced to zero below.
    assign wb_en = RegWriteW & (RdW != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[RdW] = ResultW;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state: IF/ID register and register file.
    // Reset wins over a coincident writeback and over a held (stalled)
    // instruction.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'd0;
            valid_q   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
            regs_q    <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with writeback bypass.
    // The register file is written at the end of the cycle, so a value
    // being written back this cycle is routed straight to the read port.
    // ------------------------------------------------------------------
    always_comb begin
        if (wb_en && (RdW == rs1)) begin
            RD1D = ResultW;
        end else if (rs1 == 5'd0) begin
            RD1D = 32'd0;
        end else begin
            RD1D = regs_q[rs1];
        end

        if (wb_en && (RdW == rs2)) begin
            RD2D = ResultW;
        end else if (rs2 == 5'd0) begin
            RD2D = 32'd0;
        end else begin
            RD2D = regs_q[rs2];
        end
    end

    // ------------------------------------------------------------------
    // Immediate generator
    // ------------------------------------------------------------------
    always_comb begin
        imm_ext = 32'd0;
        unique case (instr_q[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
            OP_STORE:
                imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            OP_BRANCH:
                imm_ext = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                           instr_q[30:25], instr_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_ext = {instr_q[31:12], 12'd0};
            OP_JAL:
                imm_ext = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                           instr_q[20], instr_q[30:21], 1'b0};
            default:
                imm_ext = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign InstrD   = instr_q;
    assign PCPlus4D = pcplus4_q;
    assign ValidD   = valid_q;
    // Modulo-2^32 subtraction: a flushed slot (PCPlus4D = 0) reads as
    // 32'hFFFFFFFC, which downstream logic never uses since ValidD = 0.
    assign PCD      = pcplus4_q - 32'd4;
    assign Rs1D     = rs1;
    assign Rs2D     = rs2;
    assign RdD      = instr_q[11:7];
    assign ImmExtD  = imm_ext;

endmodule
